div_32bits_seq: RTL and testbench



---
 rtl/div_pkg.sv | 26 ++
 rtl/adder_32bits.sv | 14 +
 rtl/div_32bits_seq.sv | 160 ++++++++++++++++
 tb/tb_div_32bits_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, encodings and helpers for the iterative RV32M divider.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/adder_32bits.sv
// Plain 32-bit ripple adder with carry in/out, shared by the divider datapath.
module adder_32bits
  import div_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            ci,
  output logic [XLEN-1:0] sum,
  output logic            co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {32'd0, ci};

endmodule

// File: rtl/div_32bits_seq.sv
// Restoring 32-bit divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// divide-by-zero and signed overflow answered in the start cycle.
module div_32bits_seq
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          state_r, state_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            is_rem_r, is_rem_s;
  logic            neg_q_r, neg_q_s;
  logic            neg_rem_r, neg_rem_s;
  logic [XLEN-1:0] dividend_r, dividend_s;
  logic [XLEN-1:0] divisor_r, divisor_s;
  logic [XLEN-1:0] rem_r, rem_s;
  logic [XLEN-1:0] quo_r, quo_s;
  logic [4:0]      cnt_r, cnt_s;

  logic            is_signed_s, is_rem_op_s, ovf_s;
  logic [XLEN-1:0] rsh_lo_s, diff_s, fix_src_s, fix_neg_val_s;
  logic            trial_co_s, accept_s, fix_neg_s, neg_co_s;

  assign is_signed_s = !((op == OP_DIVU) || (op == OP_REMU));
  assign is_rem_op_s = (op == OP_REM) || (op == OP_REMU);
  assign ovf_s       = is_signed_s && (a == OVF_Q) && (b == 32'hFFFF_FFFF);

  // r_sh[32] is rem_r[31]; r_sh[31:0] is the shifted remainder with the next dividend bit
  assign rsh_lo_s = {rem_r[XLEN-2:0], dividend_r[XLEN-1]};

  adder_32bits u_trial (
    .a   (rsh_lo_s),
    .b   (~divisor_r),
    .ci  (1'b1),
    .sum (diff_s),
    .co  (trial_co_s)
  );

  assign accept_s  = rem_r[XLEN-1] | trial_co_s;
  assign fix_src_s = is_rem_r ? rem_r : quo_r;
  assign fix_neg_s = is_rem_r ? neg_rem_r : neg_q_r;

  adder_32bits u_negate (
    .a   (~fix_src_s),
    .b   (32'd0),
    .ci  (1'b1),
    .sum (fix_neg_val_s),
    .co  (neg_co_s)
  );

  // Next-state and datapath update for IDLE / CALC / FIX
  always_comb begin
    state_s    = state_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    result_s   = result_r;
    is_rem_s   = is_rem_r;
    neg_q_s    = neg_q_r;
    neg_rem_s  = neg_rem_r;
    dividend_s = dividend_r;
    divisor_s  = divisor_r;
    rem_s      = rem_r;
    quo_s      = quo_r;
    cnt_s      = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          is_rem_s   = is_rem_op_s;
          neg_q_s    = is_signed_s & (a[XLEN-1] ^ b[XLEN-1]);
          neg_rem_s  = is_signed_s & a[XLEN-1];
          dividend_s = abs_val(a, is_signed_s & a[XLEN-1]);
          divisor_s  = abs_val(b, is_signed_s & b[XLEN-1]);
          rem_s      = 32'd0;
          quo_s      = 32'd0;
          cnt_s      = 5'd0;
          if (b == 32'd0) begin
            result_s = is_rem_op_s ? a : DIV0_Q;
            done_s   = 1'b1;
          end else if (ovf_s) begin
            result_s = is_rem_op_s ? 32'd0 : OVF_Q;
            done_s   = 1'b1;
          end else begin
            state_s = S_CALC;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        rem_s      = accept_s ? diff_s : rsh_lo_s;
        quo_s      = {quo_r[XLEN-2:0], accept_s};
        dividend_s = {dividend_r[XLEN-2:0], 1'b0};
        cnt_s      = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          state_s = S_FIX;
        end else begin
          state_s = S_CALC;
        end
      end
      S_FIX: begin
        // negating zero keeps the source value, so a zero remainder stays 0
        result_s = (fix_neg_s && !neg_co_s) ? fix_neg_val_s : fix_src_s;
        done_s   = 1'b1;
        busy_s   = 1'b0;
        state_s  = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= 32'd0;
      is_rem_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      dividend_r <= 32'd0;
      divisor_r  <= 32'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      cnt_r      <= 5'd0;
    end else begin
      state_r    <= state_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      result_r   <= result_s;
      is_rem_r   <= is_rem_s;
      neg_q_r    <= neg_q_s;
      neg_rem_r  <= neg_rem_s;
      dividend_r <= dividend_s;
      divisor_r  <= divisor_s;
      rem_r      <= rem_s;
      quo_r      <= quo_s;
      cnt_r      <= cnt_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_div_32bits_seq.sv
// Directed self-checking bench for div_32bits_seq.
module tb_div_32bits_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  div_32bits_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait for done; lat = edges after the start edge at which done is seen
  // (0 means done is visible in the cycle right after the start edge), -1 on timeout.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output bit busy_seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    lat = -1;
    if (done) begin
      lat = 0;
    end else begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (busy) busy_seen = 1'b1;
        if (done) begin
          lat = i;
          break;
        end
      end
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat; bit bs;
    do_op(2'b01, 32'd100, 32'd7, r, lat, bs);
    n_checks++;
    if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h expected %h", r, 32'd14); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'd14) begin n_fail++; $display("FAIL result_hold: got %h expected %h", result, 32'd14); end
    do_op(2'b11, 32'd100, 32'd7, r, lat, bs);
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: got %h expected %h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat; bit bs;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, lat, bs);
    n_checks++;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2: got %h expected fffffffd", r); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, lat, bs);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h expected ffffffff", r); end
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, lat, bs);
    n_checks++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2: got %h expected 00000001", r); end
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, lat, bs);
    n_checks++;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h expected fffffffd", r); end
    do_op(2'b10, 32'hFFFF_FFF8, 32'd2, r, lat, bs);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL rem_m8_2_zero: got %h expected 00000000", r); end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] r; int lat; bit bs;
    do_op(2'b01, 32'd5, 32'd0, r, lat, bs);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0: got %h expected ffffffff", r); end
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL divu_by0_latency: got %0d expected 0", lat); end
    n_checks++;
    if (bs !== 1'b0) begin n_fail++; $display("FAIL divu_by0_busy: got %b expected 0", bs); end
    do_op(2'b11, 32'd5, 32'd0, r, lat, bs);
    n_checks++;
    if (r !== 32'd5) begin n_fail++; $display("FAIL remu_by0: got %h expected 00000005", r); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, r, lat, bs);
    n_checks++;
    if (r !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_by0: got %h expected fffffff9", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat; bit bs;
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bs);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h expected 80000000", r); end
    n_checks++;
    if (lat !== 0 || bs !== 1'b0) begin n_fail++; $display("FAIL div_ovf_timing: lat=%0d busy_seen=%b expected 0 0", lat, bs); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bs);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL rem_ovf: got %h expected 00000000", r); end
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bs);
    n_checks++;
    if (r !== 32'd0 || lat !== 33) begin n_fail++; $display("FAIL divu_no_ovf: got %h lat=%0d expected 00000000 lat=33", r, lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd8; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    n_checks++;
    if (lat !== 33 || result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL start_while_busy: lat=%0d result=%h expected lat=33 result=ffffffff", lat, result);
    end
    // still inside the done cycle: this start is taken at the next edge
    start = 1'b1; op = 2'b01; a = 32'd8; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_on_done_busy: got %b expected 1", busy); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    n_checks++;
    if (lat !== 33 || result !== 32'd4) begin
      n_fail++;
      $display("FAIL start_on_done: lat=%0d result=%h expected lat=33 result=00000004", lat, result);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; int lat; bit bs; bit done_seen;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen !== 1'b0) begin n_fail++; $display("FAIL reset_abandons: done seen=%b expected 0", done_seen); end
    do_op(2'b01, 32'd9, 32'd3, r, lat, bs);
    n_checks++;
    if (r !== 32'd3 || lat !== 33) begin
      n_fail++;
      $display("FAIL after_reset_divu: got %h lat=%0d expected 00000003 lat=33", r, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
